// File: rtl/shift_reg_universal_if.sv
// Bus bundle for the universal shift register: control, parallel and serial
// inputs toward the register, plus its true/complemented and serial outputs.
interface shift_reg_universal_if #(
  parameter int WIDTH = 8
);
  logic             i_en;
  logic [2:0]       i_mode;
  logic [WIDTH-1:0] i_d;
  logic             i_ser_l;
  logic             i_ser_r;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_q_not;
  logic             o_ser_l;
  logic             o_ser_r;
  logic             o_zero;

  modport master (
    output i_en, i_mode, i_d, i_ser_l, i_ser_r,
    input  o_q, o_q_not, o_ser_l, o_ser_r, o_zero
  );

  modport slave (
    input  i_en, i_mode, i_d, i_ser_l, i_ser_r,
    output o_q, o_q_not, o_ser_l, o_ser_r, o_zero
  );
endinterface

// File: rtl/shift_reg_universal.sv
// WIDTH-bit enable-gated universal register: hold, load, shift, rotate,
// invert and clear, with registered complement and serial shift-out bits.
module shift_reg_universal #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  shift_reg_universal_if.slave  bus
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_INV  = 3'd6,
    MODE_CLR  = 3'd7
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_not_r;
  logic             ser_l_r;
  logic             ser_r_r;
  logic [WIDTH-1:0] q_next;
  logic             ser_l_next;
  logic             ser_r_next;

  assign mode = mode_e'(bus.i_mode);

  always_comb begin
    q_next     = q_r;
    ser_l_next = ser_l_r;
    ser_r_next = ser_r_r;
    if (bus.i_en) begin
      case (mode)
        MODE_HOLD: q_next = q_r;
        MODE_LOAD: q_next = bus.i_d;
        MODE_SHL: begin
          q_next     = {q_r[WIDTH-2:0], bus.i_ser_l};
          ser_l_next = q_r[WIDTH-1];
        end
        MODE_SHR: begin
          q_next     = {bus.i_ser_r, q_r[WIDTH-1:1]};
          ser_r_next = q_r[0];
        end
        MODE_ROL:  q_next = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        MODE_ROR:  q_next = {q_r[0], q_r[WIDTH-1:1]};
        MODE_INV:  q_next = ~q_r;
        MODE_CLR:  q_next = '0;
        default:   q_next = q_r;
      endcase
    end
  end

  // Complement is its own flop bank so o_q_not never sees a combinational
  // inverter delay after the clock.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q_r     <= RESET_VALUE;
      q_not_r <= ~RESET_VALUE;
      ser_l_r <= 1'b0;
      ser_r_r <= 1'b0;
    end else begin
      q_r     <= q_next;
      q_not_r <= ~q_next;
      ser_l_r <= ser_l_next;
      ser_r_r <= ser_r_next;
    end
  end

  assign bus.o_q     = q_r;
  assign bus.o_q_not = q_not_r;
  assign bus.o_ser_l = ser_l_r;
  assign bus.o_ser_r = ser_r_r;
  assign bus.o_zero  = (q_r == '0);

endmodule

// File: tb/tb_shift_reg_universal.sv
// Self-checking bench for shift_reg_universal (WIDTH=8, RESET_VALUE=8'hA5):
// a directed vector table plus hand-written multi-cycle sequences.
module tb_shift_reg_universal;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                         ROL  = 3'd4, ROR  = 3'd5, INV = 3'd6, CLR = 3'd7;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 i_clk = ~i_clk;

  shift_reg_universal_if #(.WIDTH(W)) bus ();

  shift_reg_universal #(
    .WIDTH       (W),
    .RESET_VALUE (RV)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [7:0] exp_q;
    logic       exp_sl;
    logic       exp_sr;
    logic       exp_z;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic rst, logic en, logic [2:0] mode, logic [7:0] d,
                              logic sl, logic sr, logic [7:0] q, logic esl,
                              logic esr, logic z);
    vec_t v;
    v.rst = rst; v.en = en; v.mode = mode; v.d = d; v.sl = sl; v.sr = sr;
    v.exp_q = q; v.exp_sl = esl; v.exp_sr = esr; v.exp_z = z;
    return v;
  endfunction

  task automatic drive(logic rst, logic en, logic [2:0] mode, logic [7:0] d,
                       logic sl, logic sr);
    @(negedge i_clk);
    i_rst       = rst;
    bus.i_en    = en;
    bus.i_mode  = mode;
    bus.i_d     = d;
    bus.i_ser_l = sl;
    bus.i_ser_r = sr;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(string name, logic [7:0] q, logic sl, logic sr, logic z);
    n_tests++;
    if (bus.o_q !== q) begin
      n_fail++;
      $display("FAIL %s o_q: got %h expected %h", name, bus.o_q, q);
    end
    n_tests++;
    if (bus.o_q_not !== ~q) begin
      n_fail++;
      $display("FAIL %s o_q_not: got %h expected %h", name, bus.o_q_not, ~q);
    end
    n_tests++;
    if (bus.o_ser_l !== sl) begin
      n_fail++;
      $display("FAIL %s o_ser_l: got %b expected %b", name, bus.o_ser_l, sl);
    end
    n_tests++;
    if (bus.o_ser_r !== sr) begin
      n_fail++;
      $display("FAIL %s o_ser_r: got %b expected %b", name, bus.o_ser_r, sr);
    end
    n_tests++;
    if (bus.o_zero !== z) begin
      n_fail++;
      $display("FAIL %s o_zero: got %b expected %b", name, bus.o_zero, z);
    end
  endtask

  initial begin
    //               rst en mode  d      sl sr  q      sl sr z
    vecs[0]  = mk(1, 1, LOAD, 8'hFF, 0, 0, 8'hA5, 0, 0, 0);
    vecs[1]  = mk(0, 1, LOAD, 8'h3C, 0, 0, 8'h3C, 0, 0, 0);
    vecs[2]  = mk(0, 0, INV,  8'h00, 0, 0, 8'h3C, 0, 0, 0);
    vecs[3]  = mk(0, 0, INV,  8'h00, 1, 1, 8'h3C, 0, 0, 0);
    vecs[4]  = mk(0, 0, INV,  8'h00, 0, 0, 8'h3C, 0, 0, 0);
    vecs[5]  = mk(0, 1, LOAD, 8'h81, 0, 0, 8'h81, 0, 0, 0);
    vecs[6]  = mk(0, 1, SHL,  8'h00, 1, 0, 8'h03, 1, 0, 0);
    vecs[7]  = mk(0, 1, SHR,  8'h00, 0, 0, 8'h01, 1, 1, 0);
    vecs[8]  = mk(0, 1, LOAD, 8'h01, 0, 0, 8'h01, 1, 1, 0);
    vecs[9]  = mk(0, 1, CLR,  8'h00, 0, 0, 8'h00, 1, 1, 1);
    vecs[10] = mk(0, 1, INV,  8'h00, 0, 0, 8'hFF, 1, 1, 0);
    vecs[11] = mk(0, 1, ROL,  8'h00, 0, 0, 8'hFF, 1, 1, 0);
    vecs[12] = mk(0, 1, LOAD, 8'h96, 1, 1, 8'h96, 1, 1, 0);
    vecs[13] = mk(0, 1, ROL,  8'h00, 0, 0, 8'h2D, 1, 1, 0);
    vecs[14] = mk(0, 1, HOLD, 8'hFF, 1, 1, 8'h2D, 1, 1, 0);
    vecs[15] = mk(0, 1, SHR,  8'h00, 0, 1, 8'h96, 1, 1, 0);
    vecs[16] = mk(0, 1, SHL,  8'h00, 0, 1, 8'h2C, 1, 1, 0);
    vecs[17] = mk(0, 1, SHL,  8'h00, 0, 0, 8'h58, 0, 1, 0);
    vecs[18] = mk(0, 1, SHR,  8'h00, 1, 0, 8'h2C, 0, 0, 0);
    vecs[19] = mk(0, 1, ROR,  8'h00, 1, 1, 8'h16, 0, 0, 0);
    vecs[20] = mk(1, 1, SHL,  8'h00, 1, 1, 8'hA5, 0, 0, 0);

    i_rst = 1'b0; bus.i_en = 1'b0; bus.i_mode = HOLD; bus.i_d = '0;
    bus.i_ser_l = 1'b0; bus.i_ser_r = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sl, vecs[i].sr);
      check($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_sl, vecs[i].exp_sr,
            vecs[i].exp_z);
    end

    // ROR wrap: eight rotations return the starting value
    drive(0, 1, LOAD, 8'h96, 0, 0);
    drive(0, 1, ROR, 8'h00, 1, 1);
    check("ror_first", 8'h4B, 0, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 1, ROR, 8'h00, 0, 0);
    check("ror_wrap", 8'h96, 0, 0, 0);

    // ROL wrap
    for (int i = 0; i < 8; i++) drive(0, 1, ROL, 8'h00, 1, 0);
    check("rol_wrap", 8'h96, 0, 0, 0);

    // WIDTH SHLs with zero fill from all-ones
    drive(0, 1, LOAD, 8'hFF, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 1, SHL, 8'h00, 0, 0);
    check("shl_7", 8'h80, 1, 0, 0);
    drive(0, 1, SHL, 8'h00, 0, 0);
    check("shl_8_zero", 8'h00, 1, 0, 1);

    // Reset in the middle of a shift sequence
    drive(0, 1, LOAD, 8'hF0, 0, 0);
    drive(0, 1, SHL, 8'h00, 0, 0);
    check("mid_shl1", 8'hE0, 1, 0, 0);
    drive(1, 1, SHL, 8'h00, 1, 1);
    check("mid_rst", 8'hA5, 0, 0, 0);
    drive(0, 1, SHL, 8'h00, 0, 0);
    check("mid_shl3", 8'h4A, 1, 0, 0);
    drive(0, 1, SHL, 8'h00, 1, 0);
    check("mid_shl4", 8'h95, 0, 0, 0);

    // Mode changing every cycle, disabled edges in between
    drive(0, 1, INV, 8'h00, 0, 0);
    check("alt_inv", 8'h6A, 0, 0, 0);
    drive(0, 0, CLR, 8'h00, 0, 0);
    check("alt_dis", 8'h6A, 0, 0, 0);
    drive(0, 1, SHR, 8'h00, 0, 1);
    check("alt_shr", 8'hB5, 0, 0, 0);
    drive(0, 1, SHR, 8'h00, 0, 0);
    check("alt_shr2", 8'h5A, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
